turn_lamp_driver: RTL
=====================

TURN_LAMP_DRIVER -- requirements
Module: turn_lamp_driver

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250000, the number of clk_1m cycles per animation step (4 Hz at 1 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk_1m, input, 1, the single system clock (1 MHz).
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port state, input, 3, the lamp mode code from the upstream transfer stage.
REQ-005 SHALL have port lamp_l, output, 3, the left turn-lamp bar, with bit0 innermost.
REQ-006 SHALL have port lamp_r, output, 3, the right turn-lamp bar, with bit0 innermost.
REQ-007 SHALL have port head, output, 1, the headlamp.
REQ-008 SHALL have port rev, output, 1, the reverse lamp.
REQ-009 SHALL have port brake, output, 1, the stop lamp.
REQ-010 SHALL register every output; no output is combinational from state.

Function
REQ-011 SHALL decode the mode codes as follows: 000 = RIGHT, 011 = LEFT, 001 = FWD, 010 = REV, 111 = HAZ; 100/101/110 = HAZ (fault-safe).
REQ-012 SHALL hold internal registers mode_q (3b), presc (20b) and step (2b).
REQ-013 SHALL, on each edge where state != mode_q, load mode_q <= state and clear presc and step to 0, so that the new animation restarts from step 0.
REQ-014 SHALL, when state is unchanged, count presc 0..TICK_DIV-1 and wrap it to 0; at the wrap edge step SHALL increment modulo 4 (3 -> 0).
REQ-015 SHALL update the outputs from mode_q/step one edge after they change; the latency from a state change to the new-mode step-0 output SHALL be exactly 2 clk_1m edges.
REQ-016 SHALL produce the sweep pattern per step: step 0 = 001, step 1 = 011, step 2 = 111, step 3 = 000.
REQ-017 SHALL drive RIGHT as: lamp_r = sweep, lamp_l = 000, head = 1, rev = 0, brake = 0.
REQ-018 SHALL drive LEFT as: lamp_l = sweep, lamp_r = 000, head = 1, rev = 0, brake = 0.
REQ-019 SHALL drive FWD as: lamp_l = lamp_r = 000, head = 1, rev = 0, brake = 0.
REQ-020 SHALL drive REV as: lamp_l = lamp_r = 000, head = 0, rev = 1, brake = 0.
REQ-021 SHALL drive HAZ as: brake = 1, head = 0, rev = 0, and lamp_l = lamp_r = (step[0] == 0 ? 111 : 000), phase-locked between the two sides.
REQ-022 SHALL give a state change coincident with a presc wrap priority to the restart (REQ-013); step SHALL NOT increment on that edge.
REQ-023 SHALL restart the sequence from step 0 when state toggles away and back, even between ticks.

Reset
REQ-024 SHALL, on rst assertion, immediately force all outputs to 0, presc = 0, step = 0 and mode_q = 111, independent of the clock.
REQ-025 SHALL, on the first edge after rst release, compare state with mode_q per REQ-013; outputs SHALL reflect the mode on the following edge.
REQ-026 SHALL abandon any in-progress animation when rst is asserted mid-sweep; no partial pattern SHALL persist.

Configuration
REQ-027 SHALL use macro HAZARD_BLINK_EN: when defined, HAZ blinks per REQ-021.
REQ-028 SHALL, without HAZARD_BLINK_EN, drive HAZ as lamp_l = lamp_r = 111 steady; step still counts but SHALL NOT affect the outputs; all other modes are unchanged.

Structure
REQ-029 SHALL define, in shared package lamp_pkg, the five mode-code constants, the 2-bit sweep step type and the sweep lookup constant (4 x 3b).
REQ-030 SHALL implement presc in a sub-module tick_gen (parameter TICK_DIV; ports clk_1m, rst, clr, tick); the step and output logic SHALL remain in turn_lamp_driver.

Verification (TICK_DIV = 4)
REQ-031 SHALL cover: state = 011 held -> after 2 edges lamp_l = 001, then every 4 edges 011, 111, 000, 001; lamp_r = 000; head = 1.
REQ-032 SHALL cover: state = 000 held -> lamp_r follows the same sequence; lamp_l stays 000.
REQ-033 SHALL cover: state = 111 with HAZARD_BLINK_EN -> lamp_l = lamp_r = 111 for 4 edges, then 000 for 4 edges, alternating; brake = 1. Without the macro -> lamp_l = lamp_r = 111 steady.
REQ-034 SHALL cover: state switches 011 -> 000 at step 2 -> 2 edges later lamp_l = 000 and lamp_r = 001 (restart).
REQ-035 SHALL cover: state = 101 -> identical to HAZ. State = 010 -> rev = 1 with all other outputs 0.
REQ-036 SHALL cover: rst pulse asserted between clock edges during LEFT step 2 -> outputs are 0 immediately. After release with state = 011 -> lamp_l = 001 exactly 2 edges later.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared definitions for the turn-lamp driver: mode codes, sweep step type, sweep lookup.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package lamp_pkg;

    // Lamp mode codes presented on the state input by the upstream transfer stage.
    // Any code not listed here is treated as hazard, so a corrupted code fails safe.
    localparam logic [2:0] MODE_RIGHT = 3'b000;
    localparam logic [2:0] MODE_FWD   = 3'b001;
    localparam logic [2:0] MODE_REV   = 3'b010;
    localparam logic [2:0] MODE_LEFT  = 3'b011;
    localparam logic [2:0] MODE_HAZ   = 3'b111;

    // Animation step within the four-step sweep.
    typedef logic [1:0] sweep_step_t;

    // Sweep bar per step, bit0 innermost: 001 -> 011 -> 111 -> 000.
    // Packed index 0 is the rightmost element of the concatenation.
    localparam logic [3:0][2:0] SWEEP_LUT = {3'b000, 3'b111, 3'b011, 3'b001};

    // All lamp outputs as one registered bundle.
    typedef struct packed {
        logic [2:0] lamp_l;
        logic [2:0] lamp_r;
        logic       head;
        logic       rev;
        logic       brake;
    } lamp_out_t;

endpackage

// File: rtl/tick_gen.sv
// Animation-step prescaler: counts clk_1m cycles 0..TICK_DIV-1 and flags the wrap cycle.
// Latency: tick is high during the cycle whose closing edge wraps the count (TICK_DIV-cycle period).
// Backpressure: none; clr restarts the count from 0 on the next edge and takes priority over the wrap.
// Ports: clk_1m clock, rst async active-high reset, clr synchronous restart, tick wrap flag.
module tick_gen #(
    parameter int unsigned TICK_DIV = 250000
) (
    input  logic clk_1m,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [19:0] LAST = 20'(TICK_DIV - 1);

    logic [19:0] presc;

    always_ff @(posedge clk_1m or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (clr || (presc == LAST)) begin
            presc <= '0;
        end else begin
            presc <= presc + 20'd1;
        end
    end

    // Raw wrap flag; the consumer gives clr priority over it.
    assign tick = (presc == LAST);

endmodule

// File: rtl/turn_lamp_driver.sv
// Turn/head/reverse/stop lamp driver with a four-step sweep animation on the turn bars.
// Latency: a state change shows as the new mode's step-0 pattern exactly 2 clk_1m edges later.
// Backpressure: none; state is sampled every edge and any change restarts the animation.
// Ports: clk_1m clock (1 MHz), rst async active-high reset, state mode code,
//        lamp_l/lamp_r turn bars (bit0 innermost), head, rev, brake lamps; all outputs registered.
// Macro HAZARD_BLINK_EN: when defined, hazard bars blink on step[0]; otherwise they are steady on.
module turn_lamp_driver
    import lamp_pkg::*;
#(
    parameter int unsigned TICK_DIV = 250000
) (
    input  logic       clk_1m,
    input  logic       rst,
    input  logic [2:0] state,
    output logic [2:0] lamp_l,
    output logic [2:0] lamp_r,
    output logic       head,
    output logic       rev,
    output logic       brake
);

    logic [2:0]  mode_q;
    sweep_step_t step;
    logic        mode_chg;
    logic        tick;
    lamp_out_t   out_d;
    lamp_out_t   out_q;

    assign mode_chg = (state != mode_q);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk_1m(clk_1m),
        .rst   (rst),
        .clr   (mode_chg),
        .tick  (tick)
    );

    // A mode change wins over a coincident tick so the new animation always
    // begins at step 0, even when the change lands exactly on a wrap.
    always_ff @(posedge clk_1m or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_HAZ;
            step   <= '0;
        end else if (mode_chg) begin
            mode_q <= state;
            step   <= '0;
        end else if (tick) begin
            step   <= step + 2'd1;
        end
    end

    always_comb begin
        logic [2:0] sweep;
        out_d = '0;
        sweep = SWEEP_LUT[step];
        case (mode_q)
            MODE_RIGHT: begin
                out_d.lamp_r = sweep;
                out_d.head   = 1'b1;
            end
            MODE_LEFT: begin
                out_d.lamp_l = sweep;
                out_d.head   = 1'b1;
            end
            MODE_FWD: begin
                out_d.head   = 1'b1;
            end
            MODE_REV: begin
                out_d.rev    = 1'b1;
            end
            default: begin
                // Hazard, including the unassigned codes; both bars share one phase.
                out_d.brake  = 1'b1;
`ifdef HAZARD_BLINK_EN
                out_d.lamp_l = step[0] ? 3'b000 : 3'b111;
                out_d.lamp_r = step[0] ? 3'b000 : 3'b111;
`else
                out_d.lamp_l = 3'b111;
                out_d.lamp_r = 3'b111;
`endif
            end
        endcase
    end

    always_ff @(posedge clk_1m or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign lamp_l = out_q.lamp_l;
    assign lamp_r = out_q.lamp_r;
    assign head   = out_q.head;
    assign rev    = out_q.rev;
    assign brake  = out_q.brake;

endmodule
